// File: rtl/div_issue_ctrl.sv
// Issue/sequencing control for the shared iterative divider: starts DIV/DIVU from EX, stalls IF/ID/EX
// from detection until the result is back, holds {hi,lo} until EX advances, drains on flush.
module div_issue_ctrl #(
  parameter logic [4:0] DIV_CODE  = 5'b11010,
  parameter logic [4:0] DIVU_CODE = 5'b11011,
  parameter int         TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_alucontrol_i,
  input  logic        flush_i,
  input  logic        adv_stall_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic        div_annul_o,
  output logic        stall_o,
  output logic        hilo_valid_o,
  output logic [63:0] hilo_o,
  output logic        timeout_o
);

  localparam int             CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          start_q;
  logic          signed_q;
  logic          annul_q;
  logic          hilo_valid_q;
  logic [63:0]   hilo_q;
  logic          timeout_q;
  logic          is_div;
  logic          to_hit;

  assign is_div = ex_valid_i &
                  ((ex_alucontrol_i == DIV_CODE) | (ex_alucontrol_i == DIVU_CODE));

  // Saturating count of cycles spent waiting on the divider (BUSY plus any DRAIN).
  assign cnt_d  = (cnt_q == TO_VAL) ? cnt_q : cnt_q + CW'(1);
  assign to_hit = (cnt_d == TO_VAL);

  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      S_IDLE:  stall_o = is_div & ~flush_i;
      S_BUSY:  stall_o = 1'b1;
      S_DONE:  stall_o = 1'b0;
      S_DRAIN: stall_o = is_div;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      signed_q     <= 1'b0;
      annul_q      <= 1'b0;
      hilo_valid_q <= 1'b0;
      hilo_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      annul_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (is_div && !flush_i) begin
            state_q  <= S_BUSY;
            start_q  <= 1'b1;
            signed_q <= (ex_alucontrol_i == DIV_CODE);
            cnt_q    <= '0;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_d;
          if (div_ready_i) begin
            // A result landing together with a flush belongs to a dead instruction.
            start_q <= 1'b0;
            if (flush_i) begin
              state_q <= S_IDLE;
            end else begin
              state_q      <= S_DONE;
              hilo_q       <= div_result_i;
              hilo_valid_q <= 1'b1;
            end
          end else if (flush_i) begin
            start_q <= 1'b0;
            annul_q <= 1'b1;
            state_q <= S_DRAIN;
          end else if (to_hit) begin
            start_q   <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_DONE: begin
          if (flush_i || !adv_stall_i) begin
            state_q      <= S_IDLE;
            hilo_valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_d;
          if (div_ready_i) begin
            state_q <= S_IDLE;
          end else if (to_hit) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign div_start_o  = start_q;
  assign div_signed_o = signed_q;
  assign div_annul_o  = annul_q;
  assign hilo_valid_o = hilo_valid_q;
  assign hilo_o       = hilo_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_div_issue_ctrl;

  localparam logic [4:0] DIV  = 5'b11010;
  localparam logic [4:0] DIVU = 5'b11011;
  localparam logic [4:0] ADD  = 5'b00010;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [4:0]  ex_alucontrol_i;
  logic        flush_i;
  logic        adv_stall_i;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  logic        div_start_o;
  logic        div_signed_o;
  logic        div_annul_o;
  logic        stall_o;
  logic        hilo_valid_o;
  logic [63:0] hilo_o;
  logic        timeout_o;

  int checks   = 0;
  int failures = 0;

  div_issue_ctrl #(.DIV_CODE(DIV), .DIVU_CODE(DIVU), .TIMEOUT(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid_i      (ex_valid_i),
    .ex_alucontrol_i (ex_alucontrol_i),
    .flush_i         (flush_i),
    .adv_stall_i     (adv_stall_i),
    .div_ready_i     (div_ready_i),
    .div_result_i    (div_result_i),
    .div_start_o     (div_start_o),
    .div_signed_o    (div_signed_o),
    .div_annul_o     (div_annul_o),
    .stall_o         (stall_o),
    .hilo_valid_o    (hilo_valid_o),
    .hilo_o          (hilo_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  code;
    logic        fl;
    logic        adv;
    logic        rdy;
    logic [63:0] res;
    logic        e_stall;
    logic        e_start;
    logic        e_sgn;
    logic        e_annul;
    logic        e_hv;
    logic [63:0] e_hilo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [4:0] code, input logic fl,
                              input logic adv, input logic rdy, input logic [63:0] res,
                              input logic e_stall, input logic e_start, input logic e_sgn,
                              input logic e_annul, input logic e_hv, input logic [63:0] e_hilo);
    vec_t r;
    r.v = v; r.code = code; r.fl = fl; r.adv = adv; r.rdy = rdy; r.res = res;
    r.e_stall = e_stall; r.e_start = e_start; r.e_sgn = e_sgn;
    r.e_annul = e_annul; r.e_hv = e_hv; r.e_hilo = e_hilo;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Ends at a negedge, with reset already released at the preceding posedge+1.
  task automatic do_reset();
    rst = 1'b1;
    ex_valid_i = 1'b0; ex_alucontrol_i = '0; flush_i = 1'b0;
    adv_stall_i = 1'b0; div_ready_i = 1'b0; div_result_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // One cycle: drive inputs just after the edge, return at the negedge for sampling.
  task automatic apply(input logic v, input logic [4:0] code, input logic fl,
                       input logic adv, input logic rdy, input logic [63:0] res);
    @(posedge clk);
    #1;
    ex_valid_i = v; ex_alucontrol_i = code; flush_i = fl;
    adv_stall_i = adv; div_ready_i = rdy; div_result_i = res;
    @(negedge clk);
  endtask

  localparam logic [63:0] R35  = 64'h00000003_00000005;
  localparam logic [63:0] RNEG = 64'hFFFFFFFF_FFFFFFFE;

  int stall_hi;
  int hv_cnt;
  int annul_cnt;
  int start_cnt;

  initial begin
    tbl.push_back(mk(1, ADD,  0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 64'd0));
    tbl.push_back(mk(0, DIV,  0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 64'd0));
    tbl.push_back(mk(1, DIV,  1, 0, 0, 64'd0, 0, 0, 0, 0, 0, 64'd0));
    tbl.push_back(mk(1, DIVU, 0, 0, 0, 64'd0, 1, 0, 0, 0, 0, 64'd0));
    tbl.push_back(mk(1, DIVU, 0, 1, 0, 64'd0, 1, 1, 0, 0, 0, 64'd0));
    tbl.push_back(mk(1, DIVU, 0, 0, 1, R35,   1, 1, 0, 0, 0, 64'd0));
    tbl.push_back(mk(1, DIVU, 0, 0, 0, 64'd0, 0, 0, 0, 0, 1, R35));
    tbl.push_back(mk(1, DIV,  0, 0, 0, 64'd0, 1, 0, 0, 0, 0, R35));
    tbl.push_back(mk(1, DIV,  0, 0, 0, 64'd0, 1, 1, 1, 0, 0, R35));
    tbl.push_back(mk(1, DIV,  0, 1, 1, RNEG,  1, 1, 1, 0, 0, R35));
    tbl.push_back(mk(1, DIV,  0, 1, 0, 64'd0, 0, 0, 1, 0, 1, RNEG));
    tbl.push_back(mk(1, DIV,  1, 1, 0, 64'd0, 0, 0, 1, 0, 1, RNEG));
    tbl.push_back(mk(0, DIV,  0, 0, 0, 64'd0, 0, 0, 1, 0, 0, RNEG));

    do_reset();
    chk("rst stall", 64'(stall_o), 64'd0);
    chk("rst start", 64'(div_start_o), 64'd0);
    chk("rst signed", 64'(div_signed_o), 64'd0);
    chk("rst annul", 64'(div_annul_o), 64'd0);
    chk("rst hv", 64'(hilo_valid_o), 64'd0);
    chk("rst hilo", hilo_o, 64'd0);
    chk("rst timeout", 64'(timeout_o), 64'd0);

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].code, tbl[i].fl, tbl[i].adv, tbl[i].rdy, tbl[i].res);
      chk($sformatf("vec%0d stall", i), 64'(stall_o), 64'(tbl[i].e_stall));
      chk($sformatf("vec%0d start", i), 64'(div_start_o), 64'(tbl[i].e_start));
      chk($sformatf("vec%0d signed", i), 64'(div_signed_o), 64'(tbl[i].e_sgn));
      chk($sformatf("vec%0d annul", i), 64'(div_annul_o), 64'(tbl[i].e_annul));
      chk($sformatf("vec%0d hv", i), 64'(hilo_valid_o), 64'(tbl[i].e_hv));
      chk($sformatf("vec%0d hilo", i), hilo_o, tbl[i].e_hilo);
      chk($sformatf("vec%0d timeout", i), 64'(timeout_o), 64'd0);
    end

    // Signed 100/7, ready on the 34th busy cycle.
    do_reset();
    stall_hi = 0; hv_cnt = 0;
    apply(1, DIV, 0, 0, 0, 64'd0);
    chk("A detect stall", 64'(stall_o), 64'd1);
    if (stall_o) stall_hi++;
    for (int i = 1; i <= 34; i++) begin
      apply(1, DIV, 0, 0, (i == 34), (i == 34) ? 64'h00000002_0000000E : 64'd0);
      if (stall_o) stall_hi++;
      if (hilo_valid_o) hv_cnt++;
      if (i == 1) chk("A start", 64'(div_start_o), 64'd1);
      if (i == 1) chk("A signed", 64'(div_signed_o), 64'd1);
    end
    apply(1, DIV, 0, 0, 0, 64'd0);
    if (stall_o) stall_hi++;
    if (hilo_valid_o) hv_cnt++;
    chk("A done hv", 64'(hilo_valid_o), 64'd1);
    chk("A done stall", 64'(stall_o), 64'd0);
    chk("A done start", 64'(div_start_o), 64'd0);
    chk("A hilo", hilo_o, 64'h00000002_0000000E);
    for (int i = 0; i < 3; i++) begin
      apply(0, ADD, 0, 0, 0, 64'd0);
      if (stall_o) stall_hi++;
      if (hilo_valid_o) hv_cnt++;
    end
    chk("A stall cycles", 64'(stall_hi), 64'd35);
    chk("A hv cycles", 64'(hv_cnt), 64'd1);

    // DIVU with downstream stall held for three cycles after ready.
    do_reset();
    start_cnt = 0;
    apply(1, DIVU, 0, 0, 0, 64'd0);
    for (int i = 1; i <= 5; i++)
      apply(1, DIVU, 0, 1, (i == 5), (i == 5) ? 64'h0000000A_00000014 : 64'd0);
    for (int i = 0; i < 4; i++) begin
      apply(1, DIVU, 0, (i < 3), 0, 64'd0);
      if (div_start_o) start_cnt++;
      chk($sformatf("B hv%0d", i), 64'(hilo_valid_o), 64'd1);
      chk($sformatf("B hilo%0d", i), hilo_o, 64'h0000000A_00000014);
      chk($sformatf("B stall%0d", i), 64'(stall_o), 64'd0);
    end
    apply(0, ADD, 0, 0, 0, 64'd0);
    if (div_start_o) start_cnt++;
    chk("B hv drop", 64'(hilo_valid_o), 64'd0);
    chk("B unsigned", 64'(div_signed_o), 64'd0);
    chk("B no restart", 64'(start_cnt), 64'd0);

    // Flush on busy cycle 10, divider drains and returns on cycle 34.
    do_reset();
    hv_cnt = 0; annul_cnt = 0;
    apply(1, DIV, 0, 0, 0, 64'd0);
    for (int i = 1; i <= 10; i++) begin
      apply(1, DIV, (i == 10), 0, 0, 64'd0);
      if (hilo_valid_o) hv_cnt++;
      if (div_annul_o) annul_cnt++;
    end
    apply(0, ADD, 0, 0, 0, 64'd0);
    if (hilo_valid_o) hv_cnt++;
    if (div_annul_o) annul_cnt++;
    chk("C annul", 64'(div_annul_o), 64'd1);
    chk("C start off", 64'(div_start_o), 64'd0);
    chk("C stall off", 64'(stall_o), 64'd0);
    for (int i = 12; i <= 35; i++) begin
      apply(0, ADD, 0, 1, (i == 34), (i == 34) ? 64'hDEADBEEF_00000001 : 64'd0);
      if (hilo_valid_o) hv_cnt++;
      if (div_annul_o) annul_cnt++;
    end
    chk("C hilo kept", hilo_o, 64'd0);
    chk("C hv never", 64'(hv_cnt), 64'd0);
    chk("C annul once", 64'(annul_cnt), 64'd1);
    apply(1, DIVU, 0, 0, 0, 64'd0);
    chk("C idle accept", 64'(stall_o), 64'd1);
    apply(1, DIVU, 0, 0, 0, 64'd0);
    chk("C restart", 64'(div_start_o), 64'd1);

    // New DIV reaches EX while a flushed DIVU is still draining.
    do_reset();
    apply(1, DIVU, 0, 0, 0, 64'd0);
    for (int i = 1; i <= 3; i++) apply(1, DIVU, (i == 3), 0, 0, 64'd0);
    for (int i = 1; i <= 5; i++) begin
      apply(1, DIV, 0, 0, (i == 5), (i == 5) ? 64'h11 : 64'd0);
      chk($sformatf("D drain stall%0d", i), 64'(stall_o), 64'd1);
      chk($sformatf("D drain start%0d", i), 64'(div_start_o), 64'd0);
      if (i == 1) chk("D annul", 64'(div_annul_o), 64'd1);
      if (i == 1) chk("D signed held", 64'(div_signed_o), 64'd0);
    end
    apply(1, DIV, 0, 0, 0, 64'd0);
    chk("D idle stall", 64'(stall_o), 64'd1);
    chk("D idle start", 64'(div_start_o), 64'd0);
    chk("D idle hv", 64'(hilo_valid_o), 64'd0);
    apply(1, DIV, 0, 0, 0, 64'd0);
    chk("D start", 64'(div_start_o), 64'd1);
    chk("D signed", 64'(div_signed_o), 64'd1);

    // Flush and ready in the same cycle.
    do_reset();
    apply(1, DIV, 0, 0, 0, 64'd0);
    for (int i = 1; i <= 4; i++) apply(1, DIV, (i == 4), 0, (i == 4), (i == 4) ? 64'h7B : 64'd0);
    apply(0, ADD, 0, 0, 0, 64'd0);
    chk("E annul", 64'(div_annul_o), 64'd0);
    chk("E hv", 64'(hilo_valid_o), 64'd0);
    chk("E start", 64'(div_start_o), 64'd0);
    chk("E hilo", hilo_o, 64'd0);
    chk("E stall", 64'(stall_o), 64'd0);
    apply(1, DIV, 0, 0, 0, 64'd0);
    chk("E accept", 64'(stall_o), 64'd1);
    apply(1, DIV, 0, 0, 0, 64'd0);
    chk("E restart", 64'(div_start_o), 64'd1);

    // Divider never answers.
    do_reset();
    stall_hi = 0;
    apply(1, DIV, 0, 0, 0, 64'd0);
    if (stall_o) stall_hi++;
    for (int i = 1; i <= 64; i++) begin
      apply(1, DIV, 0, 0, 0, 64'd0);
      if (stall_o) stall_hi++;
    end
    chk("F no early timeout", 64'(timeout_o), 64'd0);
    chk("F stall cycles", 64'(stall_hi), 64'd65);
    apply(0, ADD, 0, 0, 0, 64'd0);
    chk("F timeout", 64'(timeout_o), 64'd1);
    chk("F stall released", 64'(stall_o), 64'd0);
    chk("F start off", 64'(div_start_o), 64'd0);
    apply(1, DIVU, 0, 0, 0, 64'd0);
    chk("F accept", 64'(stall_o), 64'd1);
    apply(1, DIVU, 0, 0, 1, 64'h5);
    chk("F sticky", 64'(timeout_o), 64'd1);
    do_reset();
    chk("F cleared", 64'(timeout_o), 64'd0);

    // Reset in the middle of a busy divide.
    do_reset();
    apply(1, DIV, 0, 0, 0, 64'd0);
    apply(1, DIV, 0, 0, 0, 64'd0);
    apply(1, DIV, 0, 0, 0, 64'd0);
    chk("G busy signed", 64'(div_signed_o), 64'd1);
    do_reset();
    chk("G signed", 64'(div_signed_o), 64'd0);
    chk("G start", 64'(div_start_o), 64'd0);
    chk("G stall", 64'(stall_o), 64'd0);
    chk("G hv", 64'(hilo_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequencing controller for the shared iterative divider used by the execute stage for DIV/DIVU.
- Detects a divide in EX and drives the divider start handshake.
- Stalls the front of the pipeline until the result is ready, then holds the 64-bit {hi,lo} result until EX advances.
- Handles flushes mid-operation by draining the divider without committing its result.

Parameters:
- DIV_CODE, 5'b11010: alucontrol code for signed divide.
- DIVU_CODE, 5'b11011: alucontrol code for unsigned divide.
- TIMEOUT, 64: maximum BUSY/DRAIN cycles before the error flag is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ex_valid_i  in  1  valid instruction currently in EX
- ex_alucontrol_i  in  5  EX alucontrol
- flush_i  in  1  exception/eret flush of EX and younger stages
- adv_stall_i  in  1  downstream (mem) stall; EX holds while high
- div_ready_i  in  1  divider result-valid pulse
- div_result_i  in  64  divider output {hi,lo}
- div_start_o  out  1  start level to the divider
- div_signed_o  out  1  1 = signed operation (DIV_CODE)
- div_annul_o  out  1  one-cycle pulse: current divide cancelled
- stall_o  out  1  freeze IF/ID/EX
- hilo_valid_o  out  1  hilo_o valid for the instruction in EX
- hilo_o  out  64  latched {hi,lo}
- timeout_o  out  1  sticky error flag, cleared only by rst

Behaviour:
- Reset values: state IDLE; div_start_o, div_signed_o, div_annul_o, hilo_valid_o and timeout_o all 0; hilo_o = 0; cycle counter = 0.
- is_div = ex_valid_i & (ex_alucontrol_i==DIV_CODE | ex_alucontrol_i==DIVU_CODE).
- IDLE:
  - is_div & !flush_i -> BUSY; register div_signed_o; zero the counter.
  - stall_o = is_div & !flush_i, combinational, in the same cycle.
- BUSY:
  - div_start_o = 1, stall_o = 1, counter increments.
  - div_ready_i -> latch hilo_o <= div_result_i; -> DONE. div_start_o drops the cycle after ready.
  - flush_i without div_ready_i in the same cycle -> DRAIN; div_annul_o pulses 1 cycle; div_start_o = 0 from the next cycle.
  - flush_i and div_ready_i in the same cycle -> IDLE; result discarded; no annul pulse.
- DONE:
  - hilo_valid_o = 1, stall_o = 0, div_start_o = 0.
  - flush_i -> IDLE; hilo_valid_o = 0 next cycle.
  - !adv_stall_i -> IDLE; EX advances and the result is consumed.
  - adv_stall_i -> stay; hilo_o and hilo_valid_o held stable.
  - No restart while in DONE, even though is_div is still visible.
- DRAIN:
  - Wait for div_ready_i, then IDLE; the result is never latched.
  - stall_o = is_div, so a new divide waits for the drain to finish.
  - div_signed_o held.
- Timeout: counter saturates. When it reaches TIMEOUT in BUSY or DRAIN:
  - timeout_o <= 1, state -> IDLE, stall_o released.
- Latency:
  - First stall cycle = detection cycle.
  - hilo_valid_o asserts the cycle after div_ready_i.
  - stall_o is low in that same cycle.
- Back-to-back divides: the second divide is accepted in the first IDLE cycle after DONE exits. Its start is never asserted in the exit cycle itself.
- rst mid-operation: returns to IDLE and clears all outputs. The divider is reset by the same rst.
- adv_stall_i is ignored in BUSY and DRAIN; only the DONE exit is gated by it.

Test Plan:
- Signed 100/7: is_div with DIV_CODE, ready after 34 cycles with {2,14} -> stall_o high 35 cycles, div_signed_o=1, hilo_o=64'h00000002_0000000E, hilo_valid_o for 1 cycle.
- DIVU, adv_stall_i held 3 cycles after ready -> hilo_valid_o stays 1 for 4 cycles, hilo_o stable, div_start_o not reasserted.
- flush_i at BUSY cycle 10 -> div_annul_o pulse, DRAIN, ready at cycle 34 does not update hilo_o (remains 0), state IDLE, hilo_valid_o never asserted.
- New DIV arrives during DRAIN -> stall_o=1 until drain ready; div_start_o asserts the cycle after DRAIN->IDLE.
- flush_i coincident with div_ready_i -> IDLE, no annul, no hilo_valid_o.
- div_ready_i never asserted, TIMEOUT=64 -> timeout_o=1 at counter 64, stall_o released, sticky until rst.
